// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch-resolution controller and its update queue.
package bp_pkg;

   localparam int unsigned BP_DATA_WIDTH  = 32;
   localparam int unsigned BP_QUEUE_DEPTH = 4;

   // One predictor training record; field width follows BP_DATA_WIDTH.
   typedef struct packed {
      logic [BP_DATA_WIDTH-1:0] pc;
      logic [BP_DATA_WIDTH-1:0] target;
      logic                     taken;
   } bp_update_t;

   typedef enum logic {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } bp_ctrl_state_e;

   // Jumps are always taken; the branch outcome only matters for conditional branches.
   function automatic logic bp_actual_taken(input logic jump, input logic branch_taken);
      return jump | branch_taken;
   endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Predictor update port: queue head presented with a valid/ready handshake.
interface branch_resolve_ctrl_if
   import bp_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = BP_DATA_WIDTH
) ();

   logic                  UpdValid;
   logic                  UpdReady;
   logic [DATA_WIDTH-1:0] UpdPC;
   logic [DATA_WIDTH-1:0] UpdTarget;
   logic                  UpdTaken;

   modport master (
      output UpdValid,
      output UpdPC,
      output UpdTarget,
      output UpdTaken,
      input  UpdReady
   );

   modport slave (
      input  UpdValid,
      input  UpdPC,
      input  UpdTarget,
      input  UpdTaken,
      output UpdReady
   );

endinterface

// File: rtl/bp_update_fifo.sv
// Circular FIFO of predictor training records; DEPTH must be a power of two >= 2.
module bp_update_fifo
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH = BP_QUEUE_DEPTH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  bp_update_t push_data_i,
   input  logic       pop_i,
   output bp_update_t head_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   bp_update_t       mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Status flags, head view and pointer/occupancy next-state.
   always_comb begin
      full_o   = (count_q == CNT_W'(DEPTH));
      empty_o  = (count_q == '0);
      head_o   = mem_q[rd_ptr_q];
      do_push  = push_i & ~full_o;
      do_pop   = pop_i & ~empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers wrap for free because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset empties the queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution: mispredict detection, fetch redirect/flush,
// and predictor training through a small update queue.
// Optional BP_STATS_EN adds saturating StatBranches/StatMispredicts counters.
module branch_resolve_ctrl
   import bp_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = BP_DATA_WIDTH,
   parameter int unsigned QUEUE_DEPTH = BP_QUEUE_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ResValidE,
   input  logic                  JumpE,
   input  logic                  BranchTakenE,
   input  logic                  PredictTakenE,
   input  logic [DATA_WIDTH-1:0] PredictedTargetE,
   input  logic [DATA_WIDTH-1:0] PCE,
   input  logic [DATA_WIDTH-1:0] PCTargetE,
   output logic                  RedirectF,
   output logic [DATA_WIDTH-1:0] RedirectPCF,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  BpStallE,
`ifdef BP_STATS_EN
   output logic [31:0]           StatBranches,
   output logic [31:0]           StatMispredicts,
`endif
   branch_resolve_ctrl_if.master upd
);

   bp_ctrl_state_e        state_q, state_d;
   logic [DATA_WIDTH-1:0] redir_pc_q, redir_pc_d;
   logic                  taken;
   logic                  mispredict;
   logic                  accept;
   logic                  q_full;
   logic                  q_empty;
   logic                  q_pop;
   bp_update_t            enq_data;
   bp_update_t            head;

   // Resolution datapath: actual outcome, mispredict compare, accept gate.
   always_comb begin
      taken      = bp_actual_taken(JumpE, BranchTakenE);
      mispredict = (PredictTakenE != taken) |
                   (taken & PredictTakenE & (PredictedTargetE != PCTargetE));
      accept     = ResValidE & ~q_full & (state_q == IDLE);
      enq_data.pc     = PCE;
      enq_data.target = PCTargetE;
      enq_data.taken  = taken;
      redir_pc_d = redir_pc_q;
      if (accept & mispredict)
         redir_pc_d = taken ? PCTargetE : PCE + DATA_WIDTH'(4);
   end

   // State and latched redirect target.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         redir_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         redir_pc_q <= redir_pc_d;
      end
   end

   // Next state: one redirect cycle per accepted mispredict.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept & mispredict) state_d = REDIRECT;
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Pipeline control outputs; stall uses pre-edge occupancy only.
   always_comb begin
      RedirectF   = (state_q == REDIRECT);
      FlushD      = (state_q == REDIRECT);
      FlushE      = (state_q == REDIRECT);
      RedirectPCF = (state_q == REDIRECT) ? redir_pc_q : '0;
      BpStallE    = ResValidE & q_full & (state_q == IDLE);
   end

   // Update port: queue head drives the handshake.
   always_comb begin
      upd.UpdValid  = ~q_empty;
      upd.UpdPC     = head.pc;
      upd.UpdTarget = head.target;
      upd.UpdTaken  = head.taken;
      q_pop         = ~q_empty & upd.UpdReady;
   end

   bp_update_fifo #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (accept),
      .push_data_i (enq_data),
      .pop_i       (q_pop),
      .head_o      (head),
      .full_o      (q_full),
      .empty_o     (q_empty)
   );

`ifdef BP_STATS_EN
   logic [31:0] stat_br_q;
   logic [31:0] stat_mis_q;

   // Saturating counters of accepted resolutions and accepted mispredicts.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_br_q  <= '0;
         stat_mis_q <= '0;
      end else begin
         if (accept && stat_br_q != '1)
            stat_br_q <= stat_br_q + 32'd1;
         if (accept && mispredict && stat_mis_q != '1)
            stat_mis_q <= stat_mis_q + 32'd1;
      end
   end

   assign StatBranches    = stat_br_q;
   assign StatMispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl with an update-port scoreboard.
module tb_branch_resolve_ctrl;
   import bp_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned QD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ResValidE, JumpE, BranchTakenE, PredictTakenE;
   logic [DW-1:0] PredictedTargetE, PCE, PCTargetE;
   logic          RedirectF, FlushD, FlushE, BpStallE;
   logic [DW-1:0] RedirectPCF;
`ifdef BP_STATS_EN
   logic [31:0]   StatBranches, StatMispredicts;
`endif

   branch_resolve_ctrl_if #(.DATA_WIDTH(DW)) upd_if ();

   branch_resolve_ctrl #(
      .DATA_WIDTH  (DW),
      .QUEUE_DEPTH (QD)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .ResValidE        (ResValidE),
      .JumpE            (JumpE),
      .BranchTakenE     (BranchTakenE),
      .PredictTakenE    (PredictTakenE),
      .PredictedTargetE (PredictedTargetE),
      .PCE              (PCE),
      .PCTargetE        (PCTargetE),
      .RedirectF        (RedirectF),
      .RedirectPCF      (RedirectPCF),
      .FlushD           (FlushD),
      .FlushE           (FlushE),
      .BpStallE         (BpStallE),
`ifdef BP_STATS_EN
      .StatBranches     (StatBranches),
      .StatMispredicts  (StatMispredicts),
`endif
      .upd              (upd_if)
   );

   always #5 clk = ~clk;

   bp_update_t exp_q[$];
   bp_update_t mon_e;
   int         tests = 0;
   int         fails = 0;
   int         exp_br = 0;
   int         exp_mis = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ResValidE = 1'b0; JumpE = 1'b0; BranchTakenE = 1'b0; PredictTakenE = 1'b0;
      PredictedTargetE = '0; PCE = '0; PCTargetE = '0;
   endtask

   task automatic drive(input logic j, input logic bt, input logic pt,
                        input logic [DW-1:0] ptgt, input logic [DW-1:0] pc, input logic [DW-1:0] tgt);
      ResValidE = 1'b1; JumpE = j; BranchTakenE = bt; PredictTakenE = pt;
      PredictedTargetE = ptgt; PCE = pc; PCTargetE = tgt;
   endtask

   function automatic bp_update_t mk(input logic [DW-1:0] pc, input logic [DW-1:0] tgt, input logic t);
      bp_update_t r;
      r.pc = pc; r.target = tgt; r.taken = t;
      return r;
   endfunction

   // Scoreboard: every handshake on the update port must match the oldest expected record.
   always @(negedge clk) begin
      if (!rst && upd_if.UpdValid && upd_if.UpdReady) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL upd_unexpected: got pc=%h tgt=%h taken=%b, required no update", upd_if.UpdPC, upd_if.UpdTarget, upd_if.UpdTaken);
         end else begin
            mon_e = exp_q.pop_front();
            if ({upd_if.UpdPC, upd_if.UpdTarget, upd_if.UpdTaken} !== {mon_e.pc, mon_e.target, mon_e.taken}) begin
               fails++;
               $display("FAIL upd_record: got pc=%h tgt=%h taken=%b, required pc=%h tgt=%h taken=%b",
                        upd_if.UpdPC, upd_if.UpdTarget, upd_if.UpdTaken, mon_e.pc, mon_e.target, mon_e.taken);
            end
         end
      end
   end

   task automatic drain();
      upd_if.UpdReady = 1'b1;
      repeat (QD + 2) tick();
      @(negedge clk);
      tests++;
      if (exp_q.size() != 0 || upd_if.UpdValid !== 1'b0) begin
         fails++;
         $display("FAIL drain_empty: got pending=%0d UpdValid=%b, required 0 and 0", exp_q.size(), upd_if.UpdValid);
      end
      tick();
   endtask

   task automatic test_reset();
      repeat (2) tick();
      @(negedge clk);
      tests++;
      if ({RedirectF, FlushD, FlushE, BpStallE, upd_if.UpdValid} !== 5'b0 || RedirectPCF !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got rf=%b fd=%b fe=%b st=%b uv=%b pc=%h, required all 0",
                  RedirectF, FlushD, FlushE, BpStallE, upd_if.UpdValid, RedirectPCF);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if ({RedirectF, BpStallE, upd_if.UpdValid} !== 3'b0) begin
         fails++;
         $display("FAIL reset_release: got rf=%b st=%b uv=%b, required 0 0 0", RedirectF, BpStallE, upd_if.UpdValid);
      end
      tick();
   endtask

   task automatic test_mispredict();
      upd_if.UpdReady = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h140);
      exp_q.push_back(mk(32'h100, 32'h140, 1'b1)); exp_br++; exp_mis++;
      @(negedge clk);
      tests++;
      if (RedirectF !== 1'b0) begin
         fails++; $display("FAIL mp_early: got RedirectF=%b, required 0", RedirectF);
      end
      tick();
      idle();
      @(negedge clk);
      tests++;
      if ({RedirectF, FlushD, FlushE} !== 3'b111 || RedirectPCF !== 32'h140) begin
         fails++;
         $display("FAIL mp_redirect: got rf=%b fd=%b fe=%b pc=%h, required 1 1 1 00000140", RedirectF, FlushD, FlushE, RedirectPCF);
      end
      tests++;
      if (upd_if.UpdValid !== 1'b1 || upd_if.UpdPC !== 32'h100) begin
         fails++; $display("FAIL mp_upd_t1: got uv=%b pc=%h, required 1 00000100", upd_if.UpdValid, upd_if.UpdPC);
      end
      tick();
      @(negedge clk);
      tests++;
      if (RedirectF !== 1'b0 || FlushE !== 1'b0) begin
         fails++; $display("FAIL mp_one_cycle: got rf=%b fe=%b, required 0 0", RedirectF, FlushE);
      end
      tests++;
      if (upd_if.UpdValid !== 1'b1 || upd_if.UpdPC !== 32'h100 || upd_if.UpdTaken !== 1'b1) begin
         fails++;
         $display("FAIL mp_upd_t2: got uv=%b pc=%h tk=%b, required 1 00000100 1", upd_if.UpdValid, upd_if.UpdPC, upd_if.UpdTaken);
      end
      tick();
      drain();
   endtask

   task automatic test_correct();
      upd_if.UpdReady = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 32'h200, 32'h1F0, 32'h200);
      exp_q.push_back(mk(32'h1F0, 32'h200, 1'b1)); exp_br++;
      tick();
      // Not-taken and predicted not-taken: differing targets must not count as a mispredict.
      drive(1'b0, 1'b0, 1'b0, 32'h900, 32'h1F4, 32'h300);
      exp_q.push_back(mk(32'h1F4, 32'h300, 1'b0)); exp_br++;
      @(negedge clk);
      tests++;
      if (RedirectF !== 1'b0) begin
         fails++; $display("FAIL ok_taken_noredirect: got RedirectF=%b, required 0", RedirectF);
      end
      tick();
      idle();
      @(negedge clk);
      tests++;
      if (RedirectF !== 1'b0 || FlushD !== 1'b0) begin
         fails++; $display("FAIL ok_nt_noredirect: got rf=%b fd=%b, required 0 0", RedirectF, FlushD);
      end
      tick();
      drain();
   endtask

   task automatic test_jalr_target();
      upd_if.UpdReady = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 32'h300, 32'h2F0, 32'h304);
      exp_q.push_back(mk(32'h2F0, 32'h304, 1'b1)); exp_br++; exp_mis++;
      tick();
      idle();
      @(negedge clk);
      tests++;
      if (RedirectF !== 1'b1 || RedirectPCF !== 32'h304) begin
         fails++; $display("FAIL jalr_redirect: got rf=%b pc=%h, required 1 00000304", RedirectF, RedirectPCF);
      end
      tick();
      // Predicted taken, actually not taken at the top of the address space: PC+4 wraps to 0.
      drive(1'b0, 1'b0, 1'b1, 32'h10, 32'hFFFF_FFFC, 32'h10);
      exp_q.push_back(mk(32'hFFFF_FFFC, 32'h10, 1'b0)); exp_br++; exp_mis++;
      tick();
      idle();
      @(negedge clk);
      tests++;
      if (RedirectF !== 1'b1 || RedirectPCF !== 32'h0) begin
         fails++; $display("FAIL nt_wrap_redirect: got rf=%b pc=%h, required 1 00000000", RedirectF, RedirectPCF);
      end
      tick();
      drain();
   endtask

   task automatic test_queue_full();
      logic [DW-1:0] pc;
      upd_if.UpdReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pc = 32'h400 + DW'(i * 8);
         drive(1'b0, 1'b1, 1'b1, pc + 32'h40, pc, pc + 32'h40);
         exp_q.push_back(mk(pc, pc + 32'h40, 1'b1)); exp_br++;
         @(negedge clk);
         tests++;
         if (BpStallE !== 1'b0) begin
            fails++; $display("FAIL qf_fill_stall[%0d]: got BpStallE=%b, required 0", i, BpStallE);
         end
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h480, 32'h4C0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests++;
         if (BpStallE !== 1'b1) begin
            fails++; $display("FAIL qf_stall[%0d]: got BpStallE=%b, required 1", i, BpStallE);
         end
         tick();
      end
      upd_if.UpdReady = 1'b1;
      @(negedge clk);
      tests++;
      if (BpStallE !== 1'b1) begin
         fails++; $display("FAIL qf_stall_pop_cycle: got BpStallE=%b, required 1", BpStallE);
      end
      tick();
      exp_q.push_back(mk(32'h480, 32'h4C0, 1'b0)); exp_br++;
      @(negedge clk);
      tests++;
      if (BpStallE !== 1'b0) begin
         fails++; $display("FAIL qf_release: got BpStallE=%b, required 0", BpStallE);
      end
      tick();
      idle();
      drain();
   endtask

   task automatic test_back_to_back();
      upd_if.UpdReady = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h500, 32'h580);
      exp_q.push_back(mk(32'h500, 32'h580, 1'b1)); exp_br++; exp_mis++;
      tick();
      // Wrong-path slot: another would-be mispredict that must be ignored.
      drive(1'b0, 1'b0, 1'b1, 32'h700, 32'h600, 32'h700);
      @(negedge clk);
      tests++;
      if (RedirectF !== 1'b1 || RedirectPCF !== 32'h580 || BpStallE !== 1'b0) begin
         fails++; $display("FAIL b2b_first: got rf=%b pc=%h st=%b, required 1 00000580 0", RedirectF, RedirectPCF, BpStallE);
      end
      tick();
      idle();
      @(negedge clk);
      tests++;
      if (RedirectF !== 1'b0) begin
         fails++; $display("FAIL b2b_no_second: got RedirectF=%b, required 0", RedirectF);
      end
`ifdef BP_STATS_EN
      tests++;
      if (StatBranches !== 32'(exp_br) || StatMispredicts !== 32'(exp_mis)) begin
         fails++; $display("FAIL b2b_stats: got br=%0d mis=%0d, required br=%0d mis=%0d", StatBranches, StatMispredicts, exp_br, exp_mis);
      end
`endif
      tick();
      drain();
   endtask

   task automatic test_reset_mid();
      upd_if.UpdReady = 1'b0;
      drive(1'b0, 1'b1, 1'b1, 32'h900, 32'h800, 32'h900);
      exp_q.push_back(mk(32'h800, 32'h900, 1'b1)); exp_br++;
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h804, 32'h950);
      exp_q.push_back(mk(32'h804, 32'h950, 1'b0)); exp_br++;
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h808, 32'h880);
      exp_q.push_back(mk(32'h808, 32'h880, 1'b1)); exp_br++; exp_mis++;
      tick();
      idle();
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (RedirectF !== 1'b1 || upd_if.UpdValid !== 1'b1) begin
         fails++; $display("FAIL rm_pre: got rf=%b uv=%b, required 1 1", RedirectF, upd_if.UpdValid);
      end
      tick();
      rst = 1'b0;
      exp_q.delete(); exp_br = 0; exp_mis = 0;
      @(negedge clk);
      tests++;
      if ({RedirectF, FlushD, FlushE, BpStallE, upd_if.UpdValid} !== 5'b0 || RedirectPCF !== '0) begin
         fails++;
         $display("FAIL rm_outputs: got rf=%b fd=%b fe=%b st=%b uv=%b pc=%h, required all 0",
                  RedirectF, FlushD, FlushE, BpStallE, upd_if.UpdValid, RedirectPCF);
      end
`ifdef BP_STATS_EN
      tests++;
      if (StatBranches !== 32'd0 || StatMispredicts !== 32'd0) begin
         fails++; $display("FAIL rm_stats: got br=%0d mis=%0d, required 0 0", StatBranches, StatMispredicts);
      end
`endif
      tick();
      upd_if.UpdReady = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      tests++;
      if (upd_if.UpdValid !== 1'b0) begin
         fails++; $display("FAIL rm_queue_empty: got UpdValid=%b, required 0", upd_if.UpdValid);
      end
      tick();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      upd_if.UpdReady = 1'b0;
      test_reset();
      test_mispredict();
      test_correct();
      test_jalr_target();
      test_queue_full();
      test_back_to_back();
      test_reset_mid();
      tests++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL final_pending: got %0d outstanding updates, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
